// File: rtl/text_console_writer_pkg.sv
// Shared types and constants for the text console writer.
// Optional HT handling is enabled by defining TEXT_CONSOLE_TAB_EN.
package text_pkg;

   localparam int COLS_DEF   = 80;
   localparam int ROWS_DEF   = 30;
   localparam int ADDR_W_DEF = 12;

   typedef enum logic [2:0] {
      IDLE,
      PUT,
      CLEAR,
      SCR_RD,
      SCR_WR,
      SCR_CLR
   } state_t;

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_HT    = 8'h09;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_FF    = 8'h0C;
   localparam logic [7:0] CH_CR    = 8'h0D;

   // Bytes with bit 7 set fall outside this range and are dropped.
   function automatic logic is_printable(input logic [7:0] c);
      return (c >= 8'h20) && (c <= 8'h7E);
   endfunction

endpackage

// File: rtl/text_console_writer_cursor.sv
// Cursor row/column registers for the text console writer.
// scroll_req is combinational: it flags the op that wraps off the last row.
module console_cursor
   import text_pkg::*;
#(
   parameter int COLS = COLS_DEF,
   parameter int ROWS = ROWS_DEF
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       op_adv,
   input  logic       op_nl,
   input  logic       op_cr,
   input  logic       op_back,
   input  logic       op_tab,
   input  logic       op_home,
   output logic [6:0] col,
   output logic [4:0] row,
   output logic       scroll_req
);

   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

   logic [7:0] tab_col;
   logic       tab_wrap;
   logic       wrap;
   logic       at_last_row;

   // One extra bit so (col|7)+1 cannot overflow before the COLS compare.
   assign tab_col     = {1'b0, col | 7'd7} + 8'd1;
   assign tab_wrap    = tab_col >= 8'(COLS);
   assign at_last_row = (row == LAST_ROW);
   assign wrap        = op_nl || (op_adv && (col == LAST_COL)) || (op_tab && tab_wrap);
   assign scroll_req  = wrap && at_last_row;

   always_ff @(posedge clk) begin
      if (reset || op_home) begin
         col <= '0;
         row <= '0;
      end else if (wrap) begin
         col <= '0;
         if (!at_last_row)
            row <= row + 5'd1;
      end else if (op_adv) begin
         col <= col + 7'd1;
      end else if (op_tab) begin
         col <= tab_col[6:0];
      end else if (op_cr) begin
         col <= '0;
      end else if (op_back) begin
         if (col != '0) begin
            col <= col - 7'd1;
         end else if (row != '0) begin
            col <= LAST_COL;
            row <= row - 5'd1;
         end
      end
   end

endmodule

// File: rtl/text_console_writer.sv
// Character-stream writer for the text-mode VRAM: glyph writes, control codes, clear and scroll.
// Define TEXT_CONSOLE_TAB_EN to honour HT (0x09) as a tab stop every 8 columns.
module text_console_writer
   import text_pkg::*;
#(
   parameter int COLS   = COLS_DEF,
   parameter int ROWS   = ROWS_DEF,
   parameter int ADDR_W = ADDR_W_DEF
)(
   input  logic              Clk,
   input  logic              Reset,
   input  logic [7:0]        char_in,
   input  logic              char_inv,
   input  logic              char_valid,
   output logic              char_ready,
   output logic [ADDR_W-1:0] vram_addr,
   output logic              vram_we,
   output logic [7:0]        vram_wdata,
   output logic              vram_re,
   input  logic [7:0]        vram_rdata,
   output logic [6:0]        cursor_x,
   output logic [4:0]        cursor_y,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
   localparam logic [ADDR_W-1:0] LAST_ROW0 = ADDR_W'(COLS * (ROWS - 1));
   localparam logic [ADDR_W-1:0] SCR_LAST  = ADDR_W'(COLS * (ROWS - 1) - 1);

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] row_base;
   logic [ADDR_W-1:0] cur_addr;
   logic [7:0]        wdata_q;
   logic              put_adv;
   logic              take;
   logic              op_adv, op_nl, op_cr, op_back, op_tab, op_home;
   logic              scroll_req;

   assign char_ready = (state == IDLE) && !Reset;
   assign busy       = (state != IDLE);
   assign take       = char_valid && char_ready;

   // Scroll copies write the read-back byte in the cycle it arrives.
   assign vram_wdata = (state == SCR_WR) ? vram_rdata : wdata_q;

   generate
      if (COLS == 80) begin : g_shift_add
         assign row_base = ADDR_W'({cursor_y, 6'b0}) + ADDR_W'({cursor_y, 4'b0});
      end else begin : g_mul
         assign row_base = ADDR_W'(cursor_y) * COLS_A;
      end
   endgenerate

   assign cur_addr = row_base + ADDR_W'(cursor_x);

   always_comb begin
      op_cr   = 1'b0;
      op_nl   = 1'b0;
      op_back = 1'b0;
      op_tab  = 1'b0;
      if (take) begin
         case (char_in)
            CH_CR:   op_cr   = 1'b1;
            CH_LF:   op_nl   = 1'b1;
            CH_BS:   op_back = 1'b1;
`ifdef TEXT_CONSOLE_TAB_EN
            CH_HT:   op_tab  = 1'b1;
`endif
            default: ;
         endcase
      end
   end

   // Glyph writes advance the cursor after the write cycle; clear homes it on its last cell.
   assign op_adv  = (state == PUT) && put_adv;
   assign op_home = (state == CLEAR) && (vram_addr == LAST_CELL);

   console_cursor #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_cursor (
      .clk        (Clk),
      .reset      (Reset),
      .op_adv     (op_adv),
      .op_nl      (op_nl),
      .op_cr      (op_cr),
      .op_back    (op_back),
      .op_tab     (op_tab),
      .op_home    (op_home),
      .col        (cursor_x),
      .row        (cursor_y),
      .scroll_req (scroll_req)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         vram_we   <= 1'b0;
         vram_re   <= 1'b0;
         vram_addr <= '0;
         wdata_q   <= '0;
         idx       <= '0;
         put_adv   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  if (is_printable(char_in)) begin
                     state     <= PUT;
                     vram_we   <= 1'b1;
                     vram_addr <= cur_addr;
                     wdata_q   <= {char_inv, char_in[6:0]};
                     put_adv   <= 1'b1;
                  end else if (char_in == CH_BS) begin
                     // Stepping back from column 0 lands on the previous row's last cell: addr-1 either way.
                     if (cur_addr != '0) begin
                        state     <= PUT;
                        vram_we   <= 1'b1;
                        vram_addr <= cur_addr - ADDR_W'(1);
                        wdata_q   <= CH_SPACE;
                        put_adv   <= 1'b0;
                     end
                  end else if (char_in == CH_FF) begin
                     state     <= CLEAR;
                     vram_we   <= 1'b1;
                     vram_addr <= '0;
                     wdata_q   <= CH_SPACE;
                  end else if (scroll_req) begin
                     state     <= SCR_RD;
                     vram_re   <= 1'b1;
                     vram_addr <= COLS_A;
                     idx       <= '0;
                  end
               end
            end
            PUT: begin
               vram_we <= 1'b0;
               put_adv <= 1'b0;
               if (scroll_req) begin
                  state     <= SCR_RD;
                  vram_re   <= 1'b1;
                  vram_addr <= COLS_A;
                  idx       <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            CLEAR, SCR_CLR: begin
               if (vram_addr == LAST_CELL) begin
                  state   <= IDLE;
                  vram_we <= 1'b0;
               end else begin
                  vram_addr <= vram_addr + ADDR_W'(1);
               end
            end
            SCR_RD: begin
               state     <= SCR_WR;
               vram_re   <= 1'b0;
               vram_we   <= 1'b1;
               vram_addr <= idx;
            end
            SCR_WR: begin
               if (idx == SCR_LAST) begin
                  state     <= SCR_CLR;
                  vram_addr <= LAST_ROW0;
                  wdata_q   <= CH_SPACE;
               end else begin
                  state     <= SCR_RD;
                  vram_we   <= 1'b0;
                  vram_re   <= 1'b1;
                  idx       <= idx + ADDR_W'(1);
                  vram_addr <= idx + COLS_A + ADDR_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               vram_we <= 1'b0;
               vram_re <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: vector table, corner sequences, randomized stream vs screen model.
module tb_text_console_writer;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [7:0]  char_in = 8'h00;
   logic        char_inv = 1'b0;
   logic        char_valid = 1'b0;
   logic        char_ready;
   logic [11:0] vram_addr;
   logic        vram_we;
   logic [7:0]  vram_wdata;
   logic        vram_re;
   logic [7:0]  vram_rdata;
   logic [6:0]  cursor_x;
   logic [4:0]  cursor_y;
   logic        busy;

   text_console_writer dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .char_in    (char_in),
      .char_inv   (char_inv),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .vram_addr  (vram_addr),
      .vram_we    (vram_we),
      .vram_wdata (vram_wdata),
      .vram_re    (vram_re),
      .vram_rdata (vram_rdata),
      .cursor_x   (cursor_x),
      .cursor_y   (cursor_y),
      .busy       (busy)
   );

   always #5 Clk = ~Clk;

   // VRAM model: registered read, write on the clock edge.
   logic [7:0]  mem [0:4095];
   int          wr_cnt = 0;
   int          ovl_cnt = 0;
   logic [11:0] last_waddr = '0;
   logic [7:0]  last_wdata = '0;
   logic        fill_go = 1'b0;
   int          fill_kind = 0;

   function automatic logic [7:0] fill_pat(input int k, input int i);
      logic [7:0] v;
      v = 8'h20;
      if (k == 0) v = 8'h11;
      else if (k == 1) v = (i == 80) ? 8'h42 : (8'(i) ^ 8'h5A);
      return v;
   endfunction

   always @(posedge Clk) begin
      if (fill_go) begin
         for (int i = 0; i < 4096; i++) mem[i] <= fill_pat(fill_kind, i);
      end else if (vram_we) begin
         mem[vram_addr] <= vram_wdata;
         wr_cnt         <= wr_cnt + 1;
         last_waddr     <= vram_addr;
         last_wdata     <= vram_wdata;
      end
      if (vram_re) vram_rdata <= mem[vram_addr];
      if (vram_we && vram_re) ovl_cnt <= ovl_cnt + 1;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_cur(input string name, input int x, input int y);
      chk(name, {20'd0, cursor_y, cursor_x}, {20'd0, 5'(y), 7'(x)});
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_fill(input int k);
      fill_kind = k;
      fill_go   = 1'b1;
      step();
      fill_go   = 1'b0;
   endtask

   task automatic do_reset();
      char_valid = 1'b0;
      Reset = 1'b1;
      step();
      step();
      Reset = 1'b0;
   endtask

   // Returns one cycle after the accepting edge.
   task automatic send(input logic [7:0] c, input logic inv);
      int t;
      t = 0;
      while (!char_ready && t < 10000) begin
         step();
         t++;
      end
      if (t >= 10000) chk("send_ready_timeout", 32'(t), 32'd0);
      char_in    = c;
      char_inv   = inv;
      char_valid = 1'b1;
      step();
      char_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 6000) begin
         step();
         t++;
      end
      if (t >= 6000) chk("idle_timeout", 32'(t), 32'd0);
   endtask

   task automatic put(input logic [7:0] c, input logic inv);
      send(c, inv);
      wait_idle();
   endtask

   // Behavioural screen model.
   logic [7:0] exp_scr [0:2399];
   int         mcx, mcy;

   task automatic m_newline();
      mcx = 0;
      if (mcy == 29) begin
         for (int i = 0; i < 2320; i++) exp_scr[i] = exp_scr[i + 80];
         for (int i = 2320; i < 2400; i++) exp_scr[i] = 8'h20;
      end else begin
         mcy++;
      end
   endtask

   task automatic m_apply(input logic [7:0] c, input logic inv);
      if (c >= 8'h20 && c <= 8'h7E) begin
         exp_scr[mcy * 80 + mcx] = {inv, c[6:0]};
         if (mcx == 79) m_newline();
         else mcx++;
      end else if (c == 8'h0D) begin
         mcx = 0;
      end else if (c == 8'h0A) begin
         m_newline();
      end else if (c == 8'h08) begin
         if (mcx > 0) begin
            mcx--;
            exp_scr[mcy * 80 + mcx] = 8'h20;
         end else if (mcy > 0) begin
            mcx = 79;
            mcy--;
            exp_scr[mcy * 80 + mcx] = 8'h20;
         end
      end else if (c == 8'h0C) begin
         for (int i = 0; i < 2400; i++) exp_scr[i] = 8'h20;
         mcx = 0;
         mcy = 0;
      end
`ifdef TEXT_CONSOLE_TAB_EN
      else if (c == 8'h09) begin
         mcx = (mcx | 7) + 1;
         if (mcx >= 80) m_newline();
      end
`endif
   endtask

   task automatic cmp_screen(input string name);
      int bad, first;
      bad = 0;
      first = 0;
      for (int i = 0; i < 2400; i++) begin
         if (mem[i] !== exp_scr[i]) begin
            if (bad == 0) first = i;
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL %s cells_wrong=%0d first_addr=%0d actual=%0h required=%0h",
                  name, bad, first, mem[first], exp_scr[first]);
      end
   endtask

   typedef struct {
      logic [7:0] ch;
      logic       inv;
      int         nwr;
      int         addr;
      logic [7:0] wd;
      int         x;
      int         y;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int htx, w0, o0, bc, bad;
      logic [7:0] c, oldv;
      logic       inv;
      int         r;

      htx = 0;
`ifdef TEXT_CONSOLE_TAB_EN
      htx = 8;
`endif
      tbl[0]  = '{8'h41, 1'b1, 1, 0,  8'hC1, 1,   0};
      tbl[1]  = '{8'h62, 1'b0, 1, 1,  8'h62, 2,   0};
      tbl[2]  = '{8'h0D, 1'b0, 0, 0,  8'h00, 0,   0};
      tbl[3]  = '{8'h0A, 1'b0, 0, 0,  8'h00, 0,   1};
      tbl[4]  = '{8'h7A, 1'b0, 1, 80, 8'h7A, 1,   1};
      tbl[5]  = '{8'h08, 1'b0, 1, 80, 8'h20, 0,   1};
      tbl[6]  = '{8'h08, 1'b1, 1, 79, 8'h20, 79,  0};
      tbl[7]  = '{8'h07, 1'b0, 0, 0,  8'h00, 79,  0};
      tbl[8]  = '{8'h85, 1'b0, 0, 0,  8'h00, 79,  0};
      tbl[9]  = '{8'h7F, 1'b1, 0, 0,  8'h00, 79,  0};
      tbl[10] = '{8'h7E, 1'b1, 1, 79, 8'hFE, 0,   1};
      tbl[11] = '{8'h09, 1'b0, 0, 0,  8'h00, htx, 1};
      tbl[12] = '{8'h8D, 1'b0, 0, 0,  8'h00, htx, 1};

      do_fill(2);

      // Reset state, sampled while Reset is still high.
      Reset = 1'b1;
      step();
      step();
      chk("rst_we", 32'(vram_we), 32'd0);
      chk("rst_re", 32'(vram_re), 32'd0);
      chk("rst_addr", 32'(vram_addr), 32'd0);
      chk("rst_wdata", 32'(vram_wdata), 32'd0);
      chk("rst_ready", 32'(char_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk_cur("rst_cursor", 0, 0);
      Reset = 1'b0;

      // 'A' with inverse: write in N+1, ready again in N+2.
      send(8'h41, 1'b1);
      chk("a_we", 32'(vram_we), 32'd1);
      chk("a_addr", 32'(vram_addr), 32'd0);
      chk("a_wdata", 32'(vram_wdata), 32'hC1);
      chk("a_ready_n1", 32'(char_ready), 32'd0);
      step();
      chk("a_ready_n2", 32'(char_ready), 32'd1);
      chk_cur("a_cursor", 1, 0);

      // CR returns ready in N+1.
      send(8'h0D, 1'b0);
      chk("cr_ready_n1", 32'(char_ready), 32'd1);

      // Vector table from a fresh reset.
      do_reset();
      for (int k = 0; k < 13; k++) begin
         w0 = wr_cnt;
         put(tbl[k].ch, tbl[k].inv);
         chk($sformatf("tbl%0d_nwr", k), 32'(wr_cnt - w0), 32'(tbl[k].nwr));
         if (tbl[k].nwr != 0) begin
            chk($sformatf("tbl%0d_addr", k), 32'(last_waddr), 32'(tbl[k].addr));
            chk($sformatf("tbl%0d_wdata", k), 32'(last_wdata), 32'(tbl[k].wd));
         end
         chk_cur($sformatf("tbl%0d_cursor", k), tbl[k].x, tbl[k].y);
      end

      // End-of-row wrap, then CR LF without VRAM traffic.
      do_reset();
      repeat (5) put(8'h0A, 1'b0);
      repeat (79) put(8'h71, 1'b0);
      chk_cur("wrap_pre", 79, 5);
      w0 = wr_cnt;
      put(8'h78, 1'b0);
      chk("wrap_nwr", 32'(wr_cnt - w0), 32'd1);
      chk("wrap_addr", 32'(last_waddr), 32'd479);
      chk_cur("wrap_cursor", 0, 6);
      w0 = wr_cnt;
      put(8'h0D, 1'b0);
      put(8'h0A, 1'b0);
      chk("crlf_nwr", 32'(wr_cnt - w0), 32'd0);
      chk_cur("crlf_cursor", 0, 7);

      // Backspace at home and at column 0.
      do_reset();
      w0 = wr_cnt;
      put(8'h08, 1'b0);
      chk("bs_home_nwr", 32'(wr_cnt - w0), 32'd0);
      chk_cur("bs_home_cursor", 0, 0);
      do_reset();
      repeat (3) put(8'h0A, 1'b0);
      w0 = wr_cnt;
      put(8'h08, 1'b0);
      chk("bs_col0_nwr", 32'(wr_cnt - w0), 32'd1);
      chk("bs_col0_addr", 32'(last_waddr), 32'd239);
      chk("bs_col0_wdata", 32'(last_wdata), 32'h20);
      chk_cur("bs_col0_cursor", 79, 2);

      // Scroll triggered by LF on the last row.
      do_fill(1);
      do_reset();
      repeat (29) put(8'h0A, 1'b0);
      repeat (10) put(8'h63, 1'b0);
      chk_cur("scr_pre", 10, 29);
      o0 = ovl_cnt;
      send(8'h0A, 1'b0);
      bc = 0;
      while (busy && bc < 6000) begin
         step();
         bc++;
      end
      chk("scr_busy_cycles", 32'(bc), 32'd4720);
      chk("scr_cell0", 32'(mem[0]), 32'h42);
      bad = 0;
      for (int i = 0; i < 2320; i++) begin
         oldv = (i + 80 >= 2320 && i + 80 < 2330) ? 8'h63 : fill_pat(1, i + 80);
         if (mem[i] !== oldv) bad++;
      end
      chk("scr_body_bad", 32'(bad), 32'd0);
      bad = 0;
      for (int i = 2320; i < 2400; i++) if (mem[i] !== 8'h20) bad++;
      chk("scr_lastrow_bad", 32'(bad), 32'd0);
      chk_cur("scr_cursor", 0, 29);
      chk("scr_overlap", 32'(ovl_cnt - o0), 32'd0);

      // Reset in the middle of a clear.
      do_fill(0);
      do_reset();
      send(8'h0C, 1'b0);
      repeat (1000) step();
      chk("ff_addr_at_1000", 32'(vram_addr), 32'd1000);
      Reset = 1'b1;
      step();
      chk("ff_rst_we", 32'(vram_we), 32'd0);
      chk("ff_rst_busy", 32'(busy), 32'd0);
      chk("ff_rst_ready", 32'(char_ready), 32'd0);
      chk_cur("ff_rst_cursor", 0, 0);
      w0 = wr_cnt;
      step();
      Reset = 1'b0;
      step();
      chk("ff_ready_after", 32'(char_ready), 32'd1);
      chk("ff_no_writes", 32'(wr_cnt - w0), 32'd0);
      bad = 0;
      for (int i = 0; i < 1000; i++) if (mem[i] !== 8'h20) bad++;
      chk("ff_cleared_bad", 32'(bad), 32'd0);
      bad = 0;
      for (int i = 1001; i < 2400; i++) if (mem[i] !== 8'h11) bad++;
      chk("ff_untouched_bad", 32'(bad), 32'd0);

      // Randomized stream against the screen model.
      do_reset();
      put(8'h0C, 1'b0);
      for (int i = 0; i < 2400; i++) exp_scr[i] = 8'h20;
      mcx = 0;
      mcy = 0;
      cmp_screen("rnd_start_screen");
      for (int n = 0; n < 300; n++) begin
         r   = $urandom_range(0, 99);
         inv = 1'($urandom_range(0, 1));
         if (r < 70)      c = 8'($urandom_range(32, 126));
         else if (r < 76) c = 8'h0D;
         else if (r < 84) c = 8'h0A;
         else if (r < 92) c = 8'h08;
         else if (r < 96) c = 8'h09;
         else             c = 8'($urandom_range(0, 255));
         m_apply(c, inv);
         put(c, inv);
         chk_cur($sformatf("rnd%0d_cursor_ch%0h", n, c), mcx, mcy);
         if (n % 60 == 59) cmp_screen($sformatf("rnd%0d_screen", n));
      end
      cmp_screen("rnd_end_screen");
      chk("we_re_overlap_total", 32'(ovl_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
